// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory between the instruction fetch stage (IF) and
// the data access of the MEM stage (lw/sw). Data always wins over fetch, and
// only one memory access is outstanding at a time. While a requester's access
// is pending, its stall line holds that pipeline stage.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   if_req/if_addr        fetch request and PC, held until if_ready
//   if_rdata/if_ready     fetched word and one-cycle completion pulse
//   dm_rd/dm_wr           data read/write request, held until dm_ready
//   dm_addr/dm_wdata      data address and store data
//   dm_rdata/dm_ready     load data and one-cycle completion pulse
//   mem_en/mem_we         memory strobe (held until mem_ack) and write enable
//   mem_addr/mem_wdata    memory address and write data
//   mem_rdata/mem_ack     memory read data and access-done strobe
//   stall_if/stall_mem    combinational stalls for the IF and MEM stages
//   bus_err               sticky flag, set when an access times out
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // The abort fires on the edge where the counter would reach TIMEOUT,
    // so mem_en stays high for exactly TIMEOUT unacknowledged cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DATA_WAIT = 2'd1,
        INST_WAIT = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ready_q,  if_ready_d;
    logic              dm_ready_q,  dm_ready_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
    logic              bus_err_q,   bus_err_d;

    // Next-state and next-output logic for the arbitration FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        bus_err_d   = bus_err_q;

        case (state_q)
            IDLE: begin
                // A ready pulse marks a bubble cycle: the requester still
                // holds its request then and must not be served twice.
                if (!if_ready_q && !dm_ready_q) begin
                    if (dm_rd || dm_wr) begin
                        mem_en_d    = 1'b1;
                        mem_we_d    = dm_wr;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        state_d     = DATA_WAIT;
                    end else if (if_req) begin
                        mem_en_d   = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = if_addr;
                        state_d    = INST_WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            DATA_WAIT, INST_WAIT: begin
                if (mem_ack) begin
                    mem_en_d = 1'b0;
                    cnt_d    = CNT_ZERO;
                    state_d  = IDLE;
                    if (state_q == DATA_WAIT) begin
                        dm_ready_d = 1'b1;
                        // A store leaves the last load value in place.
                        if (!mem_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end else begin
                            dm_rdata_d = dm_rdata_q;
                        end
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else if (cnt_q >= CNT_LAST) begin
                    // Abort: release the bus, complete the owner with zero data.
                    mem_en_d  = 1'b0;
                    cnt_d     = CNT_ZERO;
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                    if (state_q == DATA_WAIT) begin
                        dm_ready_d = 1'b1;
                        dm_rdata_d = {DATA_W{1'b0}};
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = {DATA_W{1'b0}};
                    end
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                cnt_d    = CNT_ZERO;
            end
        endcase
    end

    // State and registered-output flops with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            if_rdata_q  <= {DATA_W{1'b0}};
            dm_rdata_q  <= {DATA_W{1'b0}};
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign bus_err   = bus_err_q;

    assign stall_if  = if_req & ~if_ready_q;
    assign stall_mem = (dm_rd | dm_wr) & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Random request traffic from a fetch and a data requester against a memory
// responder with random ack latency (including no ack at all). The stimulus
// process predicts, in service order, each memory access and each completion
// (data, sticky error) from a simple array model of memory; a responder checks
// the bus side and a monitor checks every ready pulse. Directed sequences at
// the end cover latency, timeout length, reset mid-access and stray acks.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          dm_rd;
    logic          dm_wr;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          stall_if;
    logic          stall_mem;
    logic          bus_err;

    // memory side: random responder, or directed values from the main process
    logic          dir_mode = 1'b0;
    logic          dir_ack  = 1'b0;
    logic [DW-1:0] dir_rdata = 32'h0;
    logic          rsp_ack  = 1'b0;
    logic [DW-1:0] rsp_rdata = 32'h0;
    assign mem_ack   = dir_mode ? dir_ack   : rsp_ack;
    assign mem_rdata = dir_mode ? dir_rdata : rsp_rdata;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct { bit is_if; logic [31:0] rdata; bit err; } sb_t;
    typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; int delay; } acc_t;
    sb_t  sb_q[$];
    acc_t acc_q[$];

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] rsp_mem [logic [31:0]];
    logic [31:0] model_dm  = 32'h0;
    bit          model_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 15));
        return a << 2;
    endfunction

    // mostly acked within the window, sometimes never acked
    function automatic int pick_delay();
        if ($urandom_range(0, 7) == 0) return $urandom_range(TO, TO + 2);
        return $urandom_range(0, TO - 1);
    endfunction

    task automatic push_data(input bit we, input logic [31:0] a, input logic [31:0] wd, input int d);
        acc_t x;
        sb_t  e;
        x.we = we; x.addr = a; x.wdata = wd; x.delay = d;
        acc_q.push_back(x);
        if (d < TO) begin
            if (we) ref_mem[a] = wd;
            else    model_dm = ref_rd(a);
        end else begin
            model_dm  = 32'h0;
            model_err = 1'b1;
        end
        e.is_if = 1'b0; e.rdata = model_dm; e.err = model_err;
        sb_q.push_back(e);
    endtask

    task automatic push_fetch(input logic [31:0] a, input int d);
        acc_t x;
        sb_t  e;
        x.we = 1'b0; x.addr = a; x.wdata = 32'h0; x.delay = d;
        acc_q.push_back(x);
        if (d < TO) begin
            e.rdata = ref_rd(a);
        end else begin
            e.rdata   = 32'h0;
            model_err = 1'b1;
        end
        e.is_if = 1'b1; e.err = model_err;
        sb_q.push_back(e);
    endtask

    task automatic wait_ready(input bit is_if);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            got = is_if ? if_ready : dm_ready;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ready_wait: is_if=%0d ready not seen within 60 cycles", is_if);
        end
    endtask

    // Monitor: every ready pulse must match the oldest predicted completion
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (if_ready || dm_ready) begin
                if (if_ready && dm_ready) begin
                    checks++;
                    errors++;
                    $display("FAIL both_ready: if_ready and dm_ready together at %0t", $time);
                end else if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_ready: if_ready=%0d dm_ready=%0d with nothing pending at %0t",
                             if_ready, dm_ready, $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("ready_owner", 64'(if_ready), 64'(e.is_if));
                    chk("ready_rdata", e.is_if ? if_rdata : dm_rdata, e.rdata);
                    chk("bus_err", 64'(bus_err), 64'(e.err));
                end
            end
        end
    end

    // Responder: checks each access against the prediction and acks it
    initial begin
        acc_t cur;
        bit   in_acc;
        int   w;
        int   exp_len;
        in_acc = 1'b0;
        w = 0;
        cur.we = 1'b0; cur.addr = 32'h0; cur.wdata = 32'h0; cur.delay = 0;
        forever begin
            @(negedge clk);
            if (dir_mode || rst) begin
                rsp_ack = 1'b0;
                in_acc  = 1'b0;
            end else if (mem_en) begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    w = 0;
                    if (acc_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL stray_access: addr %0h we %0d at %0t", mem_addr, mem_we, $time);
                        cur.we = mem_we; cur.addr = mem_addr; cur.wdata = mem_wdata; cur.delay = 0;
                    end else begin
                        cur = acc_q.pop_front();
                        chk("mem_we", 64'(mem_we), 64'(cur.we));
                        if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                    end
                end else begin
                    w++;
                end
                chk("mem_addr", mem_addr, cur.addr);
                if (w == cur.delay) begin
                    rsp_ack = 1'b1;
                    if (cur.we) begin
                        rsp_mem[cur.addr] = cur.wdata;
                        rsp_rdata = $urandom;
                    end else begin
                        rsp_rdata = rsp_mem.exists(cur.addr) ? rsp_mem[cur.addr] : dflt(cur.addr);
                    end
                end else begin
                    rsp_ack   = 1'b0;
                    rsp_rdata = $urandom;
                end
            end else begin
                if (in_acc) begin
                    exp_len = (cur.delay < TO) ? cur.delay + 1 : TO;
                    chk("access_len", 64'(w + 1), 64'(exp_len));
                    in_acc = 1'b0;
                end
                // stray acks while idle must be ignored
                rsp_ack   = ($urandom_range(0, 3) == 0);
                rsp_rdata = $urandom;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        int rw;
        int d;
        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        dm_rd = 1'b0; dm_wr = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_if_ready", 64'(if_ready), 64'd0);
        chk("rst_dm_ready", 64'(dm_ready), 64'd0);
        chk("rst_if_rdata", if_rdata, 64'd0);
        chk("rst_dm_rdata", dm_rdata, 64'd0);
        chk("rst_bus_err", 64'(bus_err), 64'd0);
        rst = 1'b0;

        // random traffic; requests are set up on the negedge that shows ready
        for (int t = 0; t < 250; t++) begin
            kind = $urandom_range(0, 2);   // 0 data, 1 fetch, 2 both at once
            if (kind != 1) begin
                rw = $urandom_range(0, 2); // 0 read, 1 write, 2 both lines high
                dm_rd = (rw != 1);
                dm_wr = (rw != 0);
                dm_addr = rnd_addr();
                dm_wdata = $urandom;
                d = pick_delay();
                push_data(dm_wr, dm_addr, dm_wdata, d);
            end else begin
                dm_rd = 1'b0;
                dm_wr = 1'b0;
            end
            if (kind != 0) begin
                if_req = 1'b1;
                if_addr = rnd_addr();
                d = pick_delay();
                push_fetch(if_addr, d);
            end else begin
                if_req = 1'b0;
            end
            if (kind != 1) begin
                wait_ready(1'b0);
                dm_rd = 1'b0;
                dm_wr = 1'b0;
            end
            if (kind != 0) begin
                wait_ready(1'b1);
            end
            if ($urandom_range(0, 3) == 0) begin
                if_req = 1'b0;
                dm_rd = 1'b0;
                dm_wr = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
        end
        if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
        repeat (8) @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        chk("acc_drained", 64'(acc_q.size()), 64'd0);

        // directed section: memory side driven from here
        dir_mode = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_err = 1'b0;
        chk("rst2_bus_err", 64'(bus_err), 64'd0);
        chk("rst2_dm_rdata", dm_rdata, 64'd0);

        // lone lw, ack in cycle 2
        begin
            sb_t e;
            e.is_if = 1'b0; e.rdata = 32'hDEAD_BEEF; e.err = 1'b0;
            dm_rd = 1'b1; dm_addr = 32'h40;
            sb_q.push_back(e);
            #1 chk("lw_stall_c0", 64'(stall_mem), 64'd1);
        end
        @(negedge clk);
        chk("lw_en_c1", 64'(mem_en), 64'd1);
        chk("lw_we_c1", 64'(mem_we), 64'd0);
        chk("lw_addr_c1", mem_addr, 64'h40);
        chk("lw_stall_c1", 64'(stall_mem), 64'd1);
        @(negedge clk);
        chk("lw_en_c2", 64'(mem_en), 64'd1);
        chk("lw_stall_c2", 64'(stall_mem), 64'd1);
        dir_ack = 1'b1; dir_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        dir_ack = 1'b0; dir_rdata = 32'h0;
        chk("lw_ready_c3", 64'(dm_ready), 64'd1);
        chk("lw_en_c3", 64'(mem_en), 64'd0);
        chk("lw_stall_c3", 64'(stall_mem), 64'd0);
        dm_rd = 1'b0;
        repeat (2) @(negedge clk);

        // timeout: no ack, mem_en for exactly TO cycles, sticky bus_err
        begin
            sb_t e;
            e.is_if = 1'b0; e.rdata = 32'h0; e.err = 1'b1;
            dm_rd = 1'b1; dm_addr = 32'h44;
            sb_q.push_back(e);
        end
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            chk("to_en_held", 64'(mem_en), 64'd1);
        end
        @(negedge clk);
        chk("to_en_drop", 64'(mem_en), 64'd0);
        chk("to_ready", 64'(dm_ready), 64'd1);
        chk("to_rdata", dm_rdata, 64'd0);
        chk("to_bus_err", 64'(bus_err), 64'd1);
        dm_rd = 1'b0;
        repeat (3) @(negedge clk);
        chk("to_bus_err_sticky", 64'(bus_err), 64'd1);

        // reset during INST_WAIT, then a late ack in IDLE
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        chk("rf_en_c1", 64'(mem_en), 64'd1);
        chk("rf_addr_c1", mem_addr, 64'h100);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rf_en_c3", 64'(mem_en), 64'd0);
        chk("rf_addr_c3", mem_addr, 64'd0);
        chk("rf_ready_c3", 64'(if_ready), 64'd0);
        chk("rf_bus_err_c3", 64'(bus_err), 64'd0);
        rst = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        dir_ack = 1'b1; dir_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        dir_ack = 1'b0;
        chk("late_ack_en", 64'(mem_en), 64'd0);
        chk("late_ack_if_ready", 64'(if_ready), 64'd0);
        chk("late_ack_if_rdata", if_rdata, 64'd0);
        repeat (3) @(negedge clk);
        chk("final_sb_drained", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
